// File: rtl/tcp_header_checksum_pkg.sv
// Shared network definitions for the TCP header checksum path.
// Holds protocol constants and the checksum FSM state type.
package tcp_header_checksum_pkg;

  localparam logic [7:0]  IP_PROTO_TCP         = 8'h06;
  localparam logic [15:0] TCP_HDR_LEN          = 16'd20;
  localparam logic [7:0]  TCP_DATA_OFFSET_BYTE = 8'h50;

  // Index of the last word summed before folding (16 words, 0..15)
  localparam logic [3:0]  LAST_WORD_IDX        = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    FOLD = 2'd2,
    OUT  = 2'd3
  } csum_state_e;

endpackage

// File: rtl/ones_complement_fold.sv
// Folds a 20-bit accumulated word sum into a 16-bit one's-complement sum.
// Purely combinational; shared with the receive-side checksum checker.
module ones_complement_fold (
  input  logic [19:0] i_sum,
  output logic [15:0] o_fold
);

  logic [16:0] firstFold;
  logic [16:0] secondFold;

  // Two end-around carry steps; after the first step the carry is at most 1,
  // so the second step can never produce another carry.
  always_comb begin
    firstFold  = {1'b0, i_sum[15:0]} + {13'd0, i_sum[19:16]};
    secondFold = {1'b0, firstFold[15:0]} + {16'd0, firstFold[16]};
    o_fold     = secondFold[15:0];
  end

endmodule

// File: rtl/tcp_header_checksum.sv
// TCP checksum generator for header-only outgoing segments.
// Sums the IPv4 pseudo-header and TCP header one 16-bit word per clock,
// folds the result and holds it until the packet generator accepts it.
// Optional macro TCP_CSUM_PAYLOAD_EN adds payload length/sum inputs.
module tcp_header_checksum
  import tcp_header_checksum_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_hdr_valid,
  output logic        o_hdr_ready,
  input  logic [15:0] i_source_port,
  input  logic [15:0] i_dest_port,
  input  logic [31:0] i_seq_number,
  input  logic [31:0] i_ack_number,
  input  logic [7:0]  i_flags,
  input  logic [15:0] i_window_size,
  input  logic [15:0] i_urgent_ptr,
  input  logic [31:0] i_src_ip,
  input  logic [31:0] i_dst_ip,
`ifdef TCP_CSUM_PAYLOAD_EN
  input  logic [15:0] i_payload_len,
  input  logic [15:0] i_payload_sum,
`endif
  output logic        o_hdr_valid,
  input  logic        i_hdr_ready,
  output logic [15:0] o_source_port,
  output logic [15:0] o_dest_port,
  output logic [31:0] o_seq_number,
  output logic [31:0] o_ack_number,
  output logic [7:0]  o_flags,
  output logic [15:0] o_window_size,
  output logic [15:0] o_urgent_ptr,
  output logic [31:0] o_src_ip,
  output logic [31:0] o_dst_ip,
  output logic [15:0] o_checksum
);

  csum_state_e state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [19:0] acc_q, acc_d;
  logic [15:0] checksum_q, checksum_d;

  logic [15:0] sourcePort_q, destPort_q, windowSize_q, urgentPtr_q;
  logic [31:0] seqNumber_q, ackNumber_q, srcIp_q, dstIp_q;
  logic [7:0]  flags_q;
  logic [15:0] tcpLen_q, payloadSum_q;

  logic [15:0] curWord;
  logic [15:0] foldedSum;
  logic        accept;

  assign accept = (state_q == IDLE) && i_hdr_valid;

  // Pick the word to add this cycle; the checksum field itself is skipped
  always_comb begin
    curWord = 16'd0;
    case (idx_q)
      4'd0:    curWord = srcIp_q[31:16];
      4'd1:    curWord = srcIp_q[15:0];
      4'd2:    curWord = dstIp_q[31:16];
      4'd3:    curWord = dstIp_q[15:0];
      4'd4:    curWord = {8'd0, IP_PROTO_TCP};
      4'd5:    curWord = tcpLen_q;
      4'd6:    curWord = sourcePort_q;
      4'd7:    curWord = destPort_q;
      4'd8:    curWord = seqNumber_q[31:16];
      4'd9:    curWord = seqNumber_q[15:0];
      4'd10:   curWord = ackNumber_q[31:16];
      4'd11:   curWord = ackNumber_q[15:0];
      4'd12:   curWord = {TCP_DATA_OFFSET_BYTE, flags_q};
      4'd13:   curWord = windowSize_q;
      4'd14:   curWord = urgentPtr_q;
      default: curWord = payloadSum_q;
    endcase
  end

  ones_complement_fold u_fold (
    .i_sum  (acc_q),
    .o_fold (foldedSum)
  );

  // Next-state logic for the accept / sum / fold / present sequence
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    checksum_d = checksum_q;
    case (state_q)
      IDLE: begin
        if (i_hdr_valid) begin
          acc_d   = 20'd0;
          idx_d   = 4'd0;
          state_d = SUM;
        end
      end
      SUM: begin
        acc_d = acc_q + {4'd0, curWord};
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST_WORD_IDX) begin
          state_d = FOLD;
        end
      end
      FOLD: begin
        checksum_d = ~foldedSum;
        state_d    = OUT;
      end
      OUT: begin
        if (i_hdr_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, accumulator and checksum registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      acc_q      <= 20'd0;
      checksum_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      checksum_q <= checksum_d;
    end
  end

  // Header field capture on accept; these double as the held outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sourcePort_q <= 16'd0;
      destPort_q   <= 16'd0;
      seqNumber_q  <= 32'd0;
      ackNumber_q  <= 32'd0;
      flags_q      <= 8'd0;
      windowSize_q <= 16'd0;
      urgentPtr_q  <= 16'd0;
      srcIp_q      <= 32'd0;
      dstIp_q      <= 32'd0;
      tcpLen_q     <= 16'd0;
      payloadSum_q <= 16'd0;
    end else if (accept) begin
      sourcePort_q <= i_source_port;
      destPort_q   <= i_dest_port;
      seqNumber_q  <= i_seq_number;
      ackNumber_q  <= i_ack_number;
      flags_q      <= i_flags;
      windowSize_q <= i_window_size;
      urgentPtr_q  <= i_urgent_ptr;
      srcIp_q      <= i_src_ip;
      dstIp_q      <= i_dst_ip;
`ifdef TCP_CSUM_PAYLOAD_EN
      tcpLen_q     <= TCP_HDR_LEN + i_payload_len;
      payloadSum_q <= i_payload_sum;
`else
      tcpLen_q     <= TCP_HDR_LEN;
      payloadSum_q <= 16'd0;
`endif
    end
  end

  assign o_hdr_ready   = (state_q == IDLE) && i_rst_n;
  assign o_hdr_valid   = (state_q == OUT);
  assign o_source_port = sourcePort_q;
  assign o_dest_port   = destPort_q;
  assign o_seq_number  = seqNumber_q;
  assign o_ack_number  = ackNumber_q;
  assign o_flags       = flags_q;
  assign o_window_size = windowSize_q;
  assign o_urgent_ptr  = urgentPtr_q;
  assign o_src_ip      = srcIp_q;
  assign o_dst_ip      = dstIp_q;
  assign o_checksum    = checksum_q;

endmodule
